// File: rtl/riscv_pkg.sv
// Shared constants for the execute-stage controller: opcodes, ALU codes,
// controller states and the branch-condition helper.
package riscv_pkg;

   // Major opcodes understood by the controller
   localparam logic [6:0] OpcR      = 7'b0110011;
   localparam logic [6:0] OpcImm    = 7'b0010011;
   localparam logic [6:0] OpcLoad   = 7'b0000011;
   localparam logic [6:0] OpcStore  = 7'b0100011;
   localparam logic [6:0] OpcBranch = 7'b1100011;

   // ALUControl encodings
   localparam logic [2:0] AluAdd = 3'b000;
   localparam logic [2:0] AluSub = 3'b001;
   localparam logic [2:0] AluAnd = 3'b010;
   localparam logic [2:0] AluOr  = 3'b011;
   localparam logic [2:0] AluSlt = 3'b101;

   // Branch funct3 encodings
   localparam logic [2:0] F3Beq = 3'b000;
   localparam logic [2:0] F3Bne = 3'b001;
   localparam logic [2:0] F3Blt = 3'b100;
   localparam logic [2:0] F3Bge = 3'b101;

   typedef enum logic [1:0] {
      StIdle,
      StExec,
      StResolve,
      StDone
   } ex_state_e;

   // Branch outcome from the ALU flags of a SUB; unknown funct3 never takes
   function automatic logic branch_cond(input logic [2:0] funct3,
                                        input logic       zero,
                                        input logic       sign);
      logic taken;
      taken = 1'b0;
      case (funct3)
         F3Beq:   taken = zero;
         F3Bne:   taken = ~zero;
         F3Blt:   taken = sign;
         F3Bge:   taken = ~sign;
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/alu_dec.sv
// Combinational instruction decoder: maps opcode/funct3/funct7b5 onto ALU
// controls and classifies the instruction as branch and/or illegal.
module alu_dec
   import riscv_pkg::*;
(
   input  logic [6:0] opcode_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7b5_i,
   output logic [2:0] alu_ctrl_o,
   output logic       alu_src_o,
   output logic       is_branch_o,
   output logic       illegal_o
);

   // Default to illegal; each recognised encoding clears the flag
   always_comb begin
      alu_ctrl_o  = AluAdd;
      alu_src_o   = 1'b0;
      is_branch_o = 1'b0;
      illegal_o   = 1'b1;
      case (opcode_i)
         OpcR, OpcImm: begin
            alu_src_o = (opcode_i == OpcImm);
            illegal_o = 1'b0;
            case (funct3_i)
               3'b000: begin
                  // funct7b5 selects SUB only for register-register ops
                  alu_ctrl_o = (opcode_i == OpcR && funct7b5_i) ? AluSub : AluAdd;
               end
               3'b111:  alu_ctrl_o = AluAnd;
               3'b110:  alu_ctrl_o = AluOr;
               3'b010:  alu_ctrl_o = AluSlt;
               default: begin
                  alu_src_o = 1'b0;
                  illegal_o = 1'b1;
               end
            endcase
         end
         OpcLoad, OpcStore: begin
            if (funct3_i == 3'b010) begin
               alu_ctrl_o = AluAdd;
               alu_src_o  = 1'b1;
               illegal_o  = 1'b0;
            end
         end
         OpcBranch: begin
            if (funct3_i == F3Beq || funct3_i == F3Bne ||
                funct3_i == F3Blt || funct3_i == F3Bge) begin
               alu_ctrl_o  = AluSub;
               is_branch_o = 1'b1;
               illegal_o   = 1'b0;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/ex_ctrl.sv
// Execute-stage controller: accepts decoded fields, strobes the datapath for
// one cycle, resolves branches from the registered ALU flags and holds the
// result until the consumer takes it. Counts completed legal operations.
module ex_ctrl
   import riscv_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic        funct7b5,
   input  logic        zero,
   input  logic        sign,
   output logic [2:0]  ALUControl,
   output logic        ALUSrc,
   output logic        ex_en,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        branch_taken,
   output logic        illegal,
   output logic [15:0] op_count
);

   ex_state_e   state_q, state_d;
   logic [2:0]  alu_ctrl_q, alu_ctrl_d;
   logic        alu_src_q, alu_src_d;
   logic        is_branch_q, is_branch_d;
   logic        illegal_q, illegal_d;
   logic [2:0]  funct3_q, funct3_d;
   logic        zero_q, zero_d;
   logic        sign_q, sign_d;
   logic        taken_q, taken_d;
   logic [15:0] op_count_q, op_count_d;

   logic [2:0]  dec_alu_ctrl;
   logic        dec_alu_src;
   logic        dec_is_branch;
   logic        dec_illegal;

   alu_dec u_alu_dec (
      .opcode_i    (opcode),
      .funct3_i    (funct3),
      .funct7b5_i  (funct7b5),
      .alu_ctrl_o  (dec_alu_ctrl),
      .alu_src_o   (dec_alu_src),
      .is_branch_o (dec_is_branch),
      .illegal_o   (dec_illegal)
   );

   // Next-state and output logic for the four-state sequencer
   always_comb begin
      state_d     = state_q;
      alu_ctrl_d  = alu_ctrl_q;
      alu_src_d   = alu_src_q;
      is_branch_d = is_branch_q;
      illegal_d   = illegal_q;
      funct3_d    = funct3_q;
      zero_d      = zero_q;
      sign_d      = sign_q;
      taken_d     = taken_q;
      op_count_d  = op_count_q;
      in_ready    = 1'b0;
      ex_en       = 1'b0;
      out_valid   = 1'b0;
      ALUControl  = AluAdd;
      ALUSrc      = 1'b0;

      unique case (state_q)
         StIdle: begin
            // Nothing is accepted in a reset cycle
            in_ready = ~reset;
            if (in_valid && !reset) begin
               alu_ctrl_d  = dec_alu_ctrl;
               alu_src_d   = dec_alu_src;
               is_branch_d = dec_is_branch;
               illegal_d   = dec_illegal;
               funct3_d    = funct3;
               taken_d     = 1'b0;
               state_d     = dec_illegal ? StDone : StExec;
            end
         end
         StExec: begin
            ex_en      = 1'b1;
            ALUControl = alu_ctrl_q;
            ALUSrc     = alu_src_q;
            zero_d     = zero;
            sign_d     = sign;
            state_d    = StResolve;
         end
         StResolve: begin
            ALUControl = alu_ctrl_q;
            ALUSrc     = alu_src_q;
            taken_d    = is_branch_q & branch_cond(funct3_q, zero_q, sign_q);
            state_d    = StDone;
         end
         StDone: begin
            out_valid  = 1'b1;
            ALUControl = alu_ctrl_q;
            ALUSrc     = alu_src_q;
            if (out_ready) begin
               state_d = StIdle;
               if (!illegal_q && op_count_q != 16'hFFFF) begin
                  op_count_d = op_count_q + 16'd1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign branch_taken = out_valid & taken_q;
   assign illegal      = out_valid & illegal_q;
   assign op_count     = op_count_q;

   // State and datapath-control registers; reset discards any in-flight op
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         alu_ctrl_q  <= AluAdd;
         alu_src_q   <= 1'b0;
         is_branch_q <= 1'b0;
         illegal_q   <= 1'b0;
         funct3_q    <= 3'b000;
         zero_q      <= 1'b0;
         sign_q      <= 1'b0;
         taken_q     <= 1'b0;
         op_count_q  <= 16'd0;
      end else begin
         state_q     <= state_d;
         alu_ctrl_q  <= alu_ctrl_d;
         alu_src_q   <= alu_src_d;
         is_branch_q <= is_branch_d;
         illegal_q   <= illegal_d;
         funct3_q    <= funct3_d;
         zero_q      <= zero_d;
         sign_q      <= sign_d;
         taken_q     <= taken_d;
         op_count_q  <= op_count_d;
      end
   end

endmodule

// File: tb/tb_ex_ctrl.sv
// Self-checking bench for ex_ctrl: a reference decode model pushes expected
// results into a queue at issue; they are popped and compared at completion.
module tb_ex_ctrl;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        funct7b5;
   logic        zero;
   logic        sign;
   logic [2:0]  ALUControl;
   logic        ALUSrc;
   logic        ex_en;
   logic        out_valid;
   logic        out_ready;
   logic        branch_taken;
   logic        illegal;
   logic [15:0] op_count;

   typedef struct {
      logic [2:0] ctrl;
      logic       src;
      logic       taken;
      logic       ill;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks;
   int          n_errors;
   logic [15:0] cnt_exp;

   ex_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .opcode       (opcode),
      .funct3       (funct3),
      .funct7b5     (funct7b5),
      .zero         (zero),
      .sign         (sign),
      .ALUControl   (ALUControl),
      .ALUSrc       (ALUSrc),
      .ex_en        (ex_en),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .branch_taken (branch_taken),
      .illegal      (illegal),
      .op_count     (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Independent reference decode of the instruction table
   function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                  input logic z, input logic s);
      exp_t e;
      e.ctrl  = 3'b000;
      e.src   = 1'b0;
      e.taken = 1'b0;
      e.ill   = 1'b1;
      if (op == 7'b0110011 || op == 7'b0010011) begin
         e.ill = 1'b0;
         e.src = (op == 7'b0010011);
         if (f3 == 3'b000)      e.ctrl = (op == 7'b0110011 && f7) ? 3'b001 : 3'b000;
         else if (f3 == 3'b111) e.ctrl = 3'b010;
         else if (f3 == 3'b110) e.ctrl = 3'b011;
         else if (f3 == 3'b010) e.ctrl = 3'b101;
         else begin
            e.ill = 1'b1;
            e.src = 1'b0;
         end
      end else if ((op == 7'b0000011 || op == 7'b0100011) && f3 == 3'b010) begin
         e.ill = 1'b0;
         e.src = 1'b1;
      end else if (op == 7'b1100011) begin
         e.ctrl = 3'b001;
         e.ill  = 1'b0;
         if (f3 == 3'b000)      e.taken = z;
         else if (f3 == 3'b001) e.taken = !z;
         else if (f3 == 3'b100) e.taken = s;
         else if (f3 == 3'b101) e.taken = !s;
         else begin
            e.ill  = 1'b1;
            e.ctrl = 3'b000;
         end
      end
      return e;
   endfunction

   // Issue one op and follow it to completion; called and returning at a negedge in IDLE
   task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic z, input logic s, input int hold, input bit poke);
      exp_t e;
      exp_t ev;
      e = model(op, f3, f7, z, s);
      opcode   = op;
      funct3   = f3;
      funct7b5 = f7;
      in_valid = 1'b1;
      check_eq("acc_rdy", 32'(in_ready), 32'd1);
      exp_q.push_back(e);
      @(negedge clk);
      // Scramble the fields: the DUT must work from its latched copy
      in_valid = 1'b0;
      opcode   = 7'($urandom);
      funct3   = 3'($urandom);
      funct7b5 = 1'($urandom);
      if (!e.ill) begin
         check_eq("ex_en", 32'(ex_en), 32'd1);
         check_eq("ex_ctrl", 32'(ALUControl), 32'(e.ctrl));
         check_eq("ex_src", 32'(ALUSrc), 32'(e.src));
         check_eq("ex_ov", 32'(out_valid), 32'd0);
         zero = z;
         sign = s;
         @(negedge clk);
         zero = ~z;
         sign = ~s;
         check_eq("res_ex_en", 32'(ex_en), 32'd0);
         check_eq("res_ov", 32'(out_valid), 32'd0);
         check_eq("res_ctrl", 32'(ALUControl), 32'(e.ctrl));
         @(negedge clk);
      end else begin
         check_eq("ill_ex_en", 32'(ex_en), 32'd0);
      end
      check_eq("done_ov", 32'(out_valid), 32'd1);
      for (int i = 0; i < hold; i++) begin
         check_eq("hold_rdy", 32'(in_ready), 32'd0);
         check_eq("hold_ex_en", 32'(ex_en), 32'd0);
         check_eq("hold_taken", 32'(branch_taken), 32'(e.taken));
         check_eq("hold_ill", 32'(illegal), 32'(e.ill));
         if (!e.ill) check_eq("hold_ctrl", 32'(ALUControl), 32'(e.ctrl));
         if (poke) begin
            in_valid = 1'b1;
            opcode   = 7'b0010011;
            funct3   = 3'b000;
         end
         @(negedge clk);
         check_eq("hold_ov", 32'(out_valid), 32'd1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      if (exp_q.size() == 0) begin
         check_eq("sb_empty", 32'(exp_q.size()), 32'd1);
      end else begin
         ev = exp_q.pop_front();
         check_eq("taken", 32'(branch_taken), 32'(ev.taken));
         check_eq("illegal", 32'(illegal), 32'(ev.ill));
         if (!ev.ill && cnt_exp != 16'hFFFF) cnt_exp = cnt_exp + 16'd1;
      end
      @(negedge clk);
      out_ready = 1'b0;
      check_eq("idle_ov", 32'(out_valid), 32'd0);
      check_eq("idle_rdy", 32'(in_ready), 32'd1);
      check_eq("idle_ex_en", 32'(ex_en), 32'd0);
      check_eq("idle_ctrl", 32'(ALUControl), 32'd0);
      check_eq("count", 32'(op_count), 32'(cnt_exp));
   endtask

   logic [6:0] op_tab [8];

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      cnt_exp   = 16'd0;
      op_tab[0] = 7'b0110011;
      op_tab[1] = 7'b0010011;
      op_tab[2] = 7'b0000011;
      op_tab[3] = 7'b0100011;
      op_tab[4] = 7'b1100011;
      op_tab[5] = 7'b1100011;
      op_tab[6] = 7'b1111111;
      op_tab[7] = 7'b0110111;

      // Reset, with a request pending that must not be taken
      reset     = 1'b1;
      in_valid  = 1'b1;
      opcode    = 7'b0010011;
      funct3    = 3'b000;
      funct7b5  = 1'b0;
      zero      = 1'b0;
      sign      = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      check_eq("rst_rdy", 32'(in_ready), 32'd0);
      check_eq("rst_ctrl", 32'(ALUControl), 32'd0);
      check_eq("rst_src", 32'(ALUSrc), 32'd0);
      check_eq("rst_ex_en", 32'(ex_en), 32'd0);
      check_eq("rst_ov", 32'(out_valid), 32'd0);
      check_eq("rst_taken", 32'(branch_taken), 32'd0);
      check_eq("rst_ill", 32'(illegal), 32'd0);
      check_eq("rst_count", 32'(op_count), 32'd0);
      @(negedge clk);
      reset    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("rst_no_acc", 32'(ex_en), 32'd0);
      check_eq("rst_rdy_up", 32'(in_ready), 32'd1);

      // Directed: R-type sub, branches, illegal, stall with ignored request
      run_op(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      run_op(7'b1100011, 3'b000, 1'b0, 1'b1, 1'b0, 0, 1'b0);
      run_op(7'b1100011, 3'b001, 1'b0, 1'b1, 1'b0, 0, 1'b0);
      run_op(7'b1100011, 3'b100, 1'b0, 1'b0, 1'b1, 0, 1'b0);
      run_op(7'b1100011, 3'b101, 1'b0, 1'b0, 1'b1, 0, 1'b0);
      run_op(7'b1100011, 3'b000, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      run_op(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      run_op(7'b1100011, 3'b010, 1'b0, 1'b1, 1'b0, 1, 1'b0);
      run_op(7'b0110011, 3'b001, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      run_op(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      run_op(7'b0100011, 3'b000, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      run_op(7'b0110011, 3'b111, 1'b0, 1'b0, 1'b0, 5, 1'b1);
      run_op(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, 5, 1'b1);

      // Random mix over the opcode table
      for (int k = 0; k < 60; k++) begin
         run_op(op_tab[$urandom_range(0, 7)], 3'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), $urandom_range(0, 2), 1'($urandom));
      end

      // Reset while an op sits in RESOLVE: discarded, counter cleared
      opcode   = 7'b0010011;
      funct3   = 3'b000;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check_eq("rr_ex_en", 32'(ex_en), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      check_eq("rr_ov0", 32'(out_valid), 32'd0);
      @(negedge clk);
      check_eq("rr_ov1", 32'(out_valid), 32'd0);
      check_eq("rr_rdy", 32'(in_ready), 32'd0);
      check_eq("rr_count", 32'(op_count), 32'd0);
      reset   = 1'b0;
      cnt_exp = 16'd0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("rr_idle_ov", 32'(out_valid), 32'd0);
         check_eq("rr_idle_rdy", 32'(in_ready), 32'd1);
      end
      run_op(7'b0010011, 3'b110, 1'b0, 1'b0, 1'b0, 0, 1'b0);

      // Saturation: preload the counter just short of full instead of
      // issuing 65534 ops, then finish three more legal ops and one illegal
      force dut.op_count_q = 16'hFFFE;
      @(negedge clk);
      release dut.op_count_q;
      cnt_exp = 16'hFFFE;
      @(negedge clk);
      check_eq("preload", 32'(op_count), 32'h0000FFFE);
      run_op(7'b0010011, 3'b000, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      check_eq("sat_first", 32'(op_count), 32'h0000FFFF);
      run_op(7'b0010011, 3'b000, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      run_op(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 2, 1'b0);
      run_op(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      check_eq("sat_hold", 32'(op_count), 32'h0000FFFF);
      check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   // Guard against a hung run
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ex_ctrl.md
EX_CTRL -- requirements
Module: ex_ctrl

Interface
REQ-001 SHALL: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL: in_valid  in  1  decoded instruction fields present; in_ready  out  1  controller accepts fields.
REQ-004 SHALL: opcode  in  7, funct3  in  3, funct7b5  in  1  instruction fields, sampled only on accept.
REQ-005 SHALL: zero  in  1, sign  in  1  ALU status from the execute datapath (sign = ALUResult[31]).
REQ-006 SHALL: ALUControl  out  3, ALUSrc  out  1  execute-datapath controls (ALUSrc=1 selects immediate).
REQ-007 SHALL: ex_en  out  1  one-cycle strobe; downstream captures ALUResult/WriteData when high.
REQ-008 SHALL: out_valid  out  1, out_ready  in  1  completion handshake; branch_taken  out  1, illegal  out  1  qualified by out_valid.
REQ-009 SHALL: op_count  out  16  number of completed legal operations.

Function
REQ-010 SHALL: FSM states IDLE, EXEC, RESOLVE, DONE; exactly one active per cycle.
REQ-011 SHALL: in_ready=1 only in IDLE; accept = in_valid & in_ready; fields latched on accept.
REQ-012 SHALL: IDLE->EXEC on legal accept; IDLE->DONE on illegal accept; else stay IDLE.
REQ-013 SHALL: EXEC->RESOLVE unconditionally; ex_en=1 only in EXEC; zero/sign registered at end of EXEC.
REQ-014 SHALL: RESOLVE->DONE unconditionally; branch_taken computed in RESOLVE from registered zero/sign, held through DONE.
REQ-015 SHALL: DONE holds out_valid=1 and all qualified outputs stable until out_ready=1; then ->IDLE.
REQ-016 SHALL: latency legal op: accept cycle T, ex_en at T+1, out_valid from T+3; illegal op: out_valid from T+1, ex_en never asserted.
REQ-017 SHALL: in_valid during EXEC/RESOLVE/DONE ignored (in_ready=0); no back-to-back accept from DONE.
REQ-018 SHALL: decode (ALUControl/ALUSrc): 0110011 R: f3=000 add 000 (f7b5=0) / sub 001 (f7b5=1), 111 and 010, 110 or 011, 010 slt 101, ALUSrc=0.
REQ-019 SHALL: 0010011 I: f3 000 add, 111 and, 110 or, 010 slt, ALUSrc=1; 0000011 f3=010 and 0100011 f3=010: add, ALUSrc=1.
REQ-020 SHALL: 1100011 branch: sub, ALUSrc=0; taken: 000 zero, 001 !zero, 100 sign, 101 !sign; non-branch taken=0.
REQ-021 SHALL: any other opcode/funct3 combination illegal: illegal=1, branch_taken=0.
REQ-022 SHALL: ALUControl/ALUSrc driven from latched decode in EXEC, RESOLVE and DONE; 000/0 in IDLE.
REQ-023 SHALL: op_count += 1 on out_valid & out_ready when illegal=0; saturates at 16'hFFFF (no wrap).

Reset
REQ-024 SHALL: reset high forces state IDLE at next edge, overriding any in-flight operation, which is discarded uncounted.
REQ-025 SHALL: reset values: in_ready=0 during reset cycle then 1; ALUControl=000, ALUSrc=0, ex_en=0, out_valid=0, branch_taken=0, illegal=0, op_count=0.
REQ-026 SHALL: in_valid asserted while reset high not accepted.

Structure
REQ-027 SHALL: shared package riscv_pkg holds opcode constants, ALUControl codes (ADD 000, SUB 001, AND 010, OR 011, SLT 101) and FSM state typedef.
REQ-028 SHALL: one combinational sub-module alu_dec maps opcode/funct3/funct7b5 to ALUControl, ALUSrc, is_branch, illegal; ex_ctrl holds FSM, registers, counter.

Verification
REQ-029 SHALL: R-type sub (0110011, f3=000, f7b5=1) accepted cycle 0 -> ex_en cycle 1 with ALUControl=001, ALUSrc=0; out_valid cycle 3, illegal=0.
REQ-030 SHALL: beq with zero=1 in EXEC -> branch_taken=1; bne same operands -> 0; blt with sign=1 -> 1; bge with sign=1 -> 0.
REQ-031 SHALL: opcode 1111111 -> out_valid cycle 1, illegal=1, no ex_en, op_count unchanged.
REQ-032 SHALL: out_ready held low 5 cycles in DONE -> outputs stable, in_ready=0, second in_valid ignored; release -> IDLE next cycle.
REQ-033 SHALL: reset pulsed during RESOLVE -> IDLE, out_valid never asserted, op_count=0.
REQ-034 SHALL: op_count preloaded to 16'hFFFE by running 65534 addi ops -> two more completions give 16'hFFFF, stays 16'hFFFF.
